// File: rtl/yp_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each written word is tagged {grant_id, payload}; writes are gated by FIFO full.
module yp_fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sel,
  input  logic                  req,
  input  logic                  full,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] data_m
);
  assign ready  = sel & ~full;
  assign wr     = req & ready;
  assign data_m = sel ? data : '0;
endmodule

module yp_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wr_en,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [ID_WIDTH-1:0]           o_grant_id,
  output logic                          o_busy
);
  localparam int            BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                             state;
  logic [ID_WIDTH-1:0]                last_id;
  logic [ID_WIDTH-1:0]                pick_id;
  logic [ID_WIDTH-1:0]                cand;
  logic                               pick_vld;
  logic [BW-1:0]                      beat_cnt;
  logic [NUM_REQ-1:0]                 lane_wr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0]              mux_data;
  logic                               g_req;
  logic                               g_last;

  // o_grant is all-zero outside BURST, so every lane output idles at zero.
  yp_fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [NUM_REQ-1:0] (
    .sel    (o_grant),
    .req    (i_req),
    .full   (i_fifo_full),
    .data   (i_data),
    .ready  (o_ready),
    .wr     (lane_wr),
    .data_m (lane_data)
  );

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_REQ; k++) mux_data |= lane_data[k];
  end

  assign g_req          = |(i_req & o_grant);
  assign g_last         = |(i_last & o_grant);
  assign o_fifo_wr_en   = |lane_wr;
  assign o_fifo_wr_data = {o_grant_id, mux_data};

  // Search starts one past the previous winner and wraps.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(last_id) + k) % NUM_REQ);
      if (!pick_vld && i_req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      beat_cnt   <= '0;
      last_id    <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          state      <= BURST;
          o_grant    <= NUM_REQ'(1) << pick_id;
          o_grant_id <= pick_id;
          last_id    <= pick_id;
          beat_cnt   <= '0;
          o_busy     <= 1'b1;
        end
        BURST: begin
          // A dropped request ends the burst even while the FIFO is full.
          if (!g_req || (!i_fifo_full && (g_last || beat_cnt == BEAT_LAST))) begin
            state      <= IDLE;
            o_grant    <= '0;
            o_grant_id <= '0;
            o_busy     <= 1'b0;
            beat_cnt   <= '0;
          end else if (!i_fifo_full) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
